// File: rtl/fpga_pll_seq_pkg.sv
// rtl/fpga_pll_seq_pkg.sv - shared state encodings and widths for the PLL sequencer
package fpga_pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

endpackage

// File: rtl/fpga_sync_2ff.sv
// rtl/fpga_sync_2ff.sv - two-flop synchroniser for asynchronous level inputs
module fpga_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fpga_pll_seq_ctrl.sv
// rtl/fpga_pll_seq_ctrl.sv - PLL reset/lock sequencer and system reset generator; FPGA_PLL_SEQ_AUTO_RELOCK_EN re-sequences on RUN lock loss
module fpga_pll_seq_ctrl
    import fpga_pll_seq_pkg::*;
#(
    parameter int N_PLL          = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic             fclk,
    input  logic             reset_n,
    input  logic [N_PLL-1:0] pll_locked,
    input  logic             restart,
    input  logic             clr_status,
    output logic             pll_areset,
    output logic             sys_reset_n,
    output logic [2:0]       state,
    output logic [3:0]       retry_cnt,
    output logic             lock_lost,
    output logic             seq_fail
);

    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [N_PLL-1:0] locked_sync;
    logic             all_lock;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               pll_areset_q, pll_areset_d;
    logic               sys_reset_n_q, sys_reset_n_d;
    logic               seq_fail_q, seq_fail_d;

    fpga_sync_2ff #(.WIDTH(N_PLL)) u_lock_sync (
        .clk   (fclk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_sync)
    );

    assign all_lock = &locked_sync;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_TC) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (all_lock) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (cnt_q == LOCK_TC) begin
                    cnt_d   = '0;
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                // A dropout is checked first so a glitch on the last count still restarts the window
                if (!all_lock) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_TC) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!all_lock) begin
`ifdef FPGA_PLL_SEQ_AUTO_RELOCK_EN
                    state_d = ST_PLL_RST;
`else
                    state_d = ST_FAIL;
`endif
                end
            end
            ST_FAIL: cnt_d = '0;
            default: begin
                cnt_d   = '0;
                state_d = ST_PLL_RST;
            end
        endcase

        if (state_d == ST_RUN) retry_d = '0;

        if (restart) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end

        // Lock loss is recorded even when restart or clr_status lands in the same cycle
        lock_lost_d = lock_lost_q;
        if (state_q == ST_RUN && !all_lock) lock_lost_d = 1'b1;
        else if (clr_status)                lock_lost_d = 1'b0;

        pll_areset_d  = (state_d == ST_PLL_RST);
        sys_reset_n_d = (state_d == ST_RUN);
        seq_fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            lock_lost_q   <= 1'b0;
            pll_areset_q  <= 1'b1;
            sys_reset_n_q <= 1'b0;
            seq_fail_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            lock_lost_q   <= lock_lost_d;
            pll_areset_q  <= pll_areset_d;
            sys_reset_n_q <= sys_reset_n_d;
            seq_fail_q    <= seq_fail_d;
        end
    end

    assign state       = state_q;
    assign retry_cnt   = retry_q;
    assign lock_lost   = lock_lost_q;
    assign pll_areset  = pll_areset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign seq_fail    = seq_fail_q;

endmodule

// File: tb/tb_fpga_pll_seq_ctrl.sv
// tb/tb_fpga_pll_seq_ctrl.sv - table-driven bench for fpga_pll_seq_ctrl, expectations follow FPGA_PLL_SEQ_AUTO_RELOCK_EN
module tb_fpga_pll_seq_ctrl;

    logic       fclk = 1'b0;
    logic       reset_n;
    logic [1:0] pll_locked;
    logic       restart;
    logic       clr_status;
    logic       pll_areset;
    logic       sys_reset_n;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic       lock_lost;
    logic       seq_fail;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [1:0] lk;
        logic       rs;
        logic       cl;
        int         n;
        logic [2:0] st;
        logic       ar;
        logic       sr;
        logic [3:0] rt;
        logic       ll;
        logic       sf;
    } vec_t;

    vec_t vecs[$];

    fpga_pll_seq_ctrl #(
        .N_PLL          (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .MAX_RETRY      (3),
        .CNT_W          (16)
    ) dut (
        .fclk        (fclk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .restart     (restart),
        .clr_status  (clr_status),
        .pll_areset  (pll_areset),
        .sys_reset_n (sys_reset_n),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .lock_lost   (lock_lost),
        .seq_fail    (seq_fail)
    );

    always #5 fclk = ~fclk;

    task automatic add(input string nm, input logic [1:0] lk, input logic rs, input logic cl,
                       input int n, input logic [2:0] st, input logic ar, input logic sr,
                       input logic [3:0] rt, input logic ll, input logic sf);
        vec_t v;
        v.name = nm; v.lk = lk; v.rs = rs; v.cl = cl; v.n = n;
        v.st = st; v.ar = ar; v.sr = sr; v.rt = rt; v.ll = ll; v.sf = sf;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [2:0] st, input logic ar, input logic sr,
                         input logic [3:0] rt, input logic ll, input logic sf);
        n_vec++;
        if ({state, pll_areset, sys_reset_n, retry_cnt, lock_lost, seq_fail} !== {st, ar, sr, rt, ll, sf}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d areset=%0b srst_n=%0b retry=%0d lost=%0b fail=%0b, want st=%0d areset=%0b srst_n=%0b retry=%0d lost=%0b fail=%0b",
                     nm, state, pll_areset, sys_reset_n, retry_cnt, lock_lost, seq_fail, st, ar, sr, rt, ll, sf);
        end
    endtask

    initial begin
        // name, locked, restart, clr, ticks | state, areset, sys_reset_n, retry, lost, fail
        add("nom_rst_hold",  2'b00, 0, 0, 3,  3'd0, 1, 0, 4'd0, 0, 0);
        add("nom_wait",      2'b00, 0, 0, 1,  3'd1, 0, 0, 4'd0, 0, 0);
        add("nom_wait_c10",  2'b00, 0, 0, 6,  3'd1, 0, 0, 4'd0, 0, 0);
        add("nom_sync_dly",  2'b11, 0, 0, 2,  3'd1, 0, 0, 4'd0, 0, 0);
        add("nom_stable",    2'b11, 0, 0, 1,  3'd2, 0, 0, 4'd0, 0, 0);
        add("nom_stable_7",  2'b11, 0, 0, 7,  3'd2, 0, 0, 4'd0, 0, 0);
        add("nom_run",       2'b11, 0, 0, 1,  3'd3, 0, 1, 4'd0, 0, 0);
        add("loss_sync",     2'b10, 0, 0, 2,  3'd3, 0, 1, 4'd0, 0, 0);
`ifdef FPGA_PLL_SEQ_AUTO_RELOCK_EN
        add("loss_relock",   2'b11, 0, 0, 1,  3'd0, 1, 0, 4'd0, 1, 0);
        add("relock_areset", 2'b11, 0, 0, 3,  3'd0, 1, 0, 4'd0, 1, 0);
        add("relock_wait",   2'b11, 0, 0, 1,  3'd1, 0, 0, 4'd0, 1, 0);
        add("relock_stable", 2'b11, 0, 0, 1,  3'd2, 0, 0, 4'd0, 1, 0);
        add("relock_st_7",   2'b11, 0, 0, 7,  3'd2, 0, 0, 4'd0, 1, 0);
        add("relock_run",    2'b11, 0, 0, 1,  3'd3, 0, 1, 4'd0, 1, 0);
        add("relock_clr",    2'b11, 0, 1, 1,  3'd3, 0, 1, 4'd0, 0, 0);
        add("relock_hold",   2'b11, 0, 0, 1,  3'd3, 0, 1, 4'd0, 0, 0);
`else
        add("loss_fail",     2'b11, 0, 0, 1,  3'd4, 0, 0, 4'd0, 1, 1);
        add("loss_fail_hold",2'b11, 0, 0, 5,  3'd4, 0, 0, 4'd0, 1, 1);
        add("loss_fail_clr", 2'b11, 0, 1, 1,  3'd4, 0, 0, 4'd0, 0, 1);
`endif
        add("part_restart",  2'b01, 1, 0, 1,  3'd0, 1, 0, 4'd0, 0, 0);
        add("part_wait1",    2'b01, 0, 0, 4,  3'd1, 0, 0, 4'd0, 0, 0);
        add("part_to1_edge", 2'b01, 0, 0, 19, 3'd1, 0, 0, 4'd0, 0, 0);
        add("part_to1",      2'b01, 0, 0, 1,  3'd0, 1, 0, 4'd1, 0, 0);
        add("part_wait2",    2'b01, 0, 0, 4,  3'd1, 0, 0, 4'd1, 0, 0);
        add("part_to2_edge", 2'b01, 0, 0, 19, 3'd1, 0, 0, 4'd1, 0, 0);
        add("part_to2",      2'b01, 0, 0, 1,  3'd0, 1, 0, 4'd2, 0, 0);
        add("part_wait3",    2'b01, 0, 0, 4,  3'd1, 0, 0, 4'd2, 0, 0);
        add("part_to3_edge", 2'b01, 0, 0, 19, 3'd1, 0, 0, 4'd2, 0, 0);
        add("part_fail",     2'b01, 0, 0, 1,  3'd4, 0, 0, 4'd3, 0, 1);
        add("part_fail_hold",2'b01, 0, 0, 5,  3'd4, 0, 0, 4'd3, 0, 1);
        add("fail_restart",  2'b00, 1, 0, 1,  3'd0, 1, 0, 4'd0, 0, 0);
        add("gl_retry1",     2'b00, 0, 0, 24, 3'd0, 1, 0, 4'd1, 0, 0);
        add("gl_stable",     2'b11, 0, 0, 5,  3'd2, 0, 0, 4'd1, 0, 0);
        add("gl_cnt5",       2'b11, 0, 0, 5,  3'd2, 0, 0, 4'd1, 0, 0);
        add("gl_drop",       2'b01, 0, 0, 1,  3'd2, 0, 0, 4'd1, 0, 0);
        add("gl_cnt7",       2'b11, 0, 0, 1,  3'd2, 0, 0, 4'd1, 0, 0);
        add("gl_back_wait",  2'b11, 0, 0, 1,  3'd1, 0, 0, 4'd1, 0, 0);
        add("gl_restable",   2'b11, 0, 0, 1,  3'd2, 0, 0, 4'd1, 0, 0);
        add("gl_fresh_7",    2'b11, 0, 0, 7,  3'd2, 0, 0, 4'd1, 0, 0);
        add("gl_run",        2'b11, 0, 0, 1,  3'd3, 0, 1, 4'd0, 0, 0);
        add("prio_sync",     2'b00, 0, 0, 2,  3'd3, 0, 1, 4'd0, 0, 0);
        add("prio_restart",  2'b00, 1, 0, 1,  3'd0, 1, 0, 4'd0, 1, 0);
        add("mid_restart",   2'b11, 1, 0, 1,  3'd0, 1, 0, 4'd0, 1, 0);
        add("mid_stable",    2'b11, 0, 0, 5,  3'd2, 0, 0, 4'd0, 1, 0);

        reset_n    = 1'b0;
        pll_locked = 2'b00;
        restart    = 1'b0;
        clr_status = 1'b0;
        #12;
        check("reset_state", 3'd0, 1, 0, 4'd0, 0, 0);
        tick();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            pll_locked = vecs[i].lk;
            restart    = vecs[i].rs;
            clr_status = vecs[i].cl;
            for (int c = 0; c < vecs[i].n; c++) begin
                tick();
                restart    = 1'b0;
                clr_status = 1'b0;
            end
            check(vecs[i].name, vecs[i].st, vecs[i].ar, vecs[i].sr, vecs[i].rt, vecs[i].ll, vecs[i].sf);
        end

        // Reset asserted between clock edges while in STABLE must act without a clock
        reset_n = 1'b0;
        #2;
        check("async_reset", 3'd0, 1, 0, 4'd0, 0, 0);
        #2;
        reset_n = 1'b1;
        tick();
        check("post_reset", 3'd0, 1, 0, 4'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_pll_seq_ctrl.md
Name: fpga_pll_seq_ctrl

Overview:
- Sequences the FPGA PLL pair and generates the system reset.
- Pulses each PLL's areset at start-up and waits for every lock with a timeout, retrying a bounded number of times.
- Releases sys_reset_n only after a continuous lock-stable window.
- Supervises loss of lock during operation.
- Sits between the board reset/oscillator inputs and fpga_pll; sys_reset_n feeds the system reset synchroniser.

Parameters:
- N_PLL, 2, number of PLL lock inputs supervised.
- PLL_RST_CYCLES, 16, fclk cycles pll_areset is held high per attempt (>=1).
- LOCK_TIMEOUT, 65535, fclk cycles allowed in WAIT_LOCK before the attempt is failed (>=1).
- STABLE_CYCLES, 1024, consecutive all-locked cycles required before reset release (>=1).
- MAX_RETRY, 3, failed attempts tolerated before FAIL (1..15).
- CNT_W, 16, width of the shared cycle counter; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- fclk, input, 1, free-running controller clock. Must be sourced from an oscillator, never from the PLL outputs being controlled.
- reset_n, input, 1, asynchronous active-low reset.
- pll_locked, input, N_PLL, raw asynchronous PLL lock flags.
- restart, input, 1, single-cycle software request to restart the sequence.
- clr_status, input, 1, single-cycle clear of the sticky flags.
- pll_areset, output, 1, active-high reset to all PLLs.
- sys_reset_n, output, 1, active-low system reset.
- state, output, 3, current state encoding.
- retry_cnt, output, 4, failed attempts in the current sequence.
- lock_lost, output, 1, sticky: lock dropped while in RUN.
- seq_fail, output, 1, high while in FAIL.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=PLL_RST, counter=0, retry_cnt=0.
  - pll_areset=1, sys_reset_n=0, lock_lost=0, seq_fail=0.
- Lock synchronisation: each pll_locked bit passes through a 2-flop synchroniser. all_lock is the AND of the synchronised bits, and the FSM sees it 2 cycles after the input.
- Outputs are registered and take effect the cycle after a state change.
- PLL_RST (0):
  - pll_areset=1; counter counts up.
  - When counter reaches PLL_RST_CYCLES-1: clear counter, go WAIT_LOCK.
- WAIT_LOCK (1):
  - pll_areset=0, sys_reset_n=0.
  - all_lock=1: clear counter, go STABLE.
  - Counter reaches LOCK_TIMEOUT-1 without lock: increment retry_cnt.
    - If the new value equals MAX_RETRY, go FAIL.
    - Otherwise go PLL_RST.
- STABLE (2):
  - Counter counts while all_lock=1.
  - all_lock=0: clear counter, go WAIT_LOCK. The timeout restarts; retry_cnt is unchanged.
  - Counter reaches STABLE_CYCLES-1: go RUN.
- RUN (3):
  - sys_reset_n=1, retry_cnt cleared to 0.
  - all_lock=0: sys_reset_n=0 on the next edge, set lock_lost=1, go PLL_RST.
- FAIL (4):
  - pll_areset=0, sys_reset_n=0, seq_fail=1.
  - Exits only on restart or reset_n.
- restart (any state): clear counter and retry_cnt, go PLL_RST. restart has priority over every other transition in the same cycle.
- clr_status clears lock_lost.
  - If clr_status and a RUN lock drop occur in the same cycle, the set wins.
  - clr_status does not affect retry_cnt or seq_fail.
- Counter: saturation is never reached because every terminal count forces a transition. Terminal-count comparisons use CNT_W-bit unsigned arithmetic.
- Unused state encodings (5-7) go to PLL_RST.

Optional Feature:
- Macro: FPGA_PLL_SEQ_AUTO_RELOCK_EN.
- Defined: loss of lock in RUN re-sequences as described above (go PLL_RST, lock_lost set).
- Undefined:
  - Loss of lock in RUN goes straight to FAIL: lock_lost=1, seq_fail=1, sys_reset_n=0, pll_areset=0.
  - Recovery requires restart or reset_n.

Decomposition:
- Package fpga_pll_seq_pkg holds:
  - State encodings ST_PLL_RST=0, ST_WAIT_LOCK=1, ST_STABLE=2, ST_RUN=3, ST_FAIL=4.
  - STATE_W=3 and RETRY_W=4.
- Sub-module fpga_sync_2ff: parameterised width, async active-low reset, reset value 0. One instance of width N_PLL.

Test Plan:
Test parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3.
- Nominal: release reset_n, raise pll_locked=2'b11 at cycle 10.
  - Required: pll_areset high for exactly 4 cycles.
  - Required: sys_reset_n rises 8 cycles after the FSM sees lock (2-cycle sync), state=3, retry_cnt=0.
- Partial lock: only pll_locked=2'b01.
  - Required: three timeouts of 20 cycles, retry_cnt 1→2→3, then state=4, seq_fail=1, sys_reset_n stays 0.
  - Then pulse restart. Required: state=0, retry_cnt=0, seq_fail=0 on the next cycle.
- Glitch in STABLE: drop pll_locked[1] for 1 cycle at stable count 5.
  - Required: return to WAIT_LOCK; a full 8 fresh stable cycles are needed before RUN; retry_cnt unchanged.
- Loss in RUN with FPGA_PLL_SEQ_AUTO_RELOCK_EN defined: drop lock.
  - Required: sys_reset_n=0 within 3 cycles of the input edge, lock_lost=1, pll_areset pulses 4 cycles, re-release after relock.
  - Then pulse clr_status. Required: lock_lost=0.
- Same loss with the macro undefined.
  - Required: state=4, seq_fail=1, pll_areset stays 0.
- Priority and reset mid-sequence:
  - restart and lock drop in the same RUN cycle: restart wins, lock_lost is still set.
  - Assert reset_n during STABLE: all outputs return to reset values asynchronously.
